// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file write-back path.
// Defines XLEN, register addressing constants and the load-result entry.
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: in-order buffer of wb_entry_t, DEPTH a power of two.
// Ports: CLK, RST (async high), push/din, pop/head, full, empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);

   wb_entry_t      mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge CLK) begin
      if (push) mem[wptr] <= din;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port driver: ALU results win, buffered loads fill gaps;
// a pending scoreboard flags rs1/rs2 read hazards.
// Ports: CLK, RST (async high); alu_*; iss_*; mem_* (valid/ready);
//   rs1/rs2 -> stall_rs1/stall_rs2; rd/DataWr/RFWr registered write port.
// Option: define WB_FORWARD_EN to add fwd_rs1/fwd_rs2/fwd_data1/fwd_data2
//   bypass outputs that remove the write-cycle stall.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              stall_rs1,
   output logic              stall_rs2,
`ifdef WB_FORWARD_EN
   output logic              fwd_rs1,
   output logic              fwd_rs2,
   output logic [XLEN-1:0]   fwd_data1,
   output logic [XLEN-1:0]   fwd_data2,
`endif
   output logic [REG_AW-1:0] rd,
   output logic [XLEN-1:0]   DataWr,
   output logic              RFWr
);
   logic      push;
   logic      pop;
   logic      full;
   logic      empty;
   wb_entry_t head;
   wb_entry_t win;
   logic      win_v;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pend_nxt;

   assign mem_ready = !full;
   assign push      = mem_valid & mem_ready;
   assign pop       = !alu_valid & !empty;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   ('{rd: mem_rd, data: mem_data}),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      win_v = alu_valid | pop;
      win   = alu_valid ? '{rd: alu_rd, data: alu_data} : head;
   end

   // Clear then set, so an issue to the same rd in the pop cycle wins.
   always_comb begin
      pend_nxt = pending;
      if (pop && head.rd != '0) pend_nxt[head.rd] = 1'b0;
      if (iss_valid && iss_rd != '0) pend_nxt[iss_rd] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd      <= '0;
         DataWr  <= '0;
         RFWr    <= 1'b0;
         pending <= '0;
      end else begin
         RFWr    <= win_v && (win.rd != '0);
         pending <= pend_nxt;
         if (win_v) begin
            rd     <= win.rd;
            DataWr <= win.data;
         end
      end
   end

   logic hit1;
   logic hit2;
   logic pend1;
   logic pend2;

   // The write in flight this cycle is not yet visible in the array.
   assign hit1  = RFWr && (rd == rs1) && (rs1 != '0);
   assign hit2  = RFWr && (rd == rs2) && (rs2 != '0);
   assign pend1 = (rs1 != '0) && pending[rs1];
   assign pend2 = (rs2 != '0) && pending[rs2];

`ifdef WB_FORWARD_EN
   assign stall_rs1 = pend1;
   assign stall_rs2 = pend2;
   assign fwd_rs1   = hit1;
   assign fwd_rs2   = hit2;
   assign fwd_data1 = DataWr;
   assign fwd_data2 = DataWr;
`else
   assign stall_rs1 = pend1 | hit1;
   assign stall_rs2 = pend2 | hit2;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed cases plus random traffic
// against a queue-based reference model.
module tb_regfile_writeback;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_data = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        stall_rs1;
   logic        stall_rs2;
   logic [4:0]  rd;
   logic [31:0] DataWr;
   logic        RFWr;
`ifdef WB_FORWARD_EN
   logic        fwd_rs1;
   logic        fwd_rs2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
`endif

   regfile_writeback dut (
      .CLK       (CLK),
      .RST       (RST),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .rs1       (rs1),
      .rs2       (rs2),
      .stall_rs1 (stall_rs1),
      .stall_rs2 (stall_rs2),
`ifdef WB_FORWARD_EN
      .fwd_rs1   (fwd_rs1),
      .fwd_rs2   (fwd_rs2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
`endif
      .rd        (rd),
      .DataWr    (DataWr),
      .RFWr      (RFWr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      int          due;
      logic [4:0]  rd;
      logic [31:0] d;
   } exp_t;

   ent_t       mfifo[$];
   exp_t       expq[$];
   logic [4:0] outst[$];
   bit         pend[32];
   bit         lw_v;
   logic [4:0] lw_rd;
   logic [31:0] lw_d;
   bit         last_took;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mfifo.delete();
      expq.delete();
      outst.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      lw_v = 1'b0;
      lw_rd = '0;
      lw_d = '0;
   endtask

   // Monitor: pops an expected write when one is due, else demands RFWr=0.
   always @(negedge CLK) begin
      if (RST) begin
         chk(RFWr == 1'b0, "rfwr_in_reset", 64'(RFWr), 64'd0);
      end else if (expq.size() > 0 && expq[0].due == cyc) begin
         exp_t e;
         e = expq.pop_front();
         chk(RFWr == 1'b1 && rd == e.rd && DataWr == e.d, "write",
             {27'd0, RFWr, rd, DataWr}, {28'd1, e.rd, e.d});
      end else begin
         chk(RFWr == 1'b0, "idle_rfwr", 64'(RFWr), 64'd0);
      end
   end

   function automatic bit exp_stall(input logic [4:0] r);
`ifdef WB_FORWARD_EN
      return (r != 0) && pend[r];
`else
      return (r != 0) && (pend[r] || (lw_v && lw_rd == r));
`endif
   endfunction

   task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit iv, input logic [4:0] ird,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2);
      bit   rdy;
      bit   wv;
      ent_t w;
      assert (!(av && ard != 0 && pend[ard]))
         else $error("ALU write to pending register %0d", ard);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      iss_valid = iss_valid; iss_valid = iv; iss_rd = ird;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      rs1 = r1; rs2 = r2;
      @(negedge CLK);
      rdy = (mfifo.size() < 4);
      chk(mem_ready == rdy, "mem_ready", 64'(mem_ready), 64'(rdy));
      chk(stall_rs1 == exp_stall(r1), "stall_rs1", 64'(stall_rs1), 64'(exp_stall(r1)));
      chk(stall_rs2 == exp_stall(r2), "stall_rs2", 64'(stall_rs2), 64'(exp_stall(r2)));
`ifdef WB_FORWARD_EN
      begin
         bit f1;
         f1 = lw_v && lw_rd == r1 && r1 != 0;
         chk(fwd_rs1 == f1, "fwd_rs1", 64'(fwd_rs1), 64'(f1));
         if (f1) chk(fwd_data1 == lw_d, "fwd_data1", 64'(fwd_data1), 64'(lw_d));
      end
`endif
      wv = 1'b0;
      w = '{rd: 5'd0, d: 32'd0};
      if (av) begin
         wv = 1'b1;
         w = '{rd: ard, d: ad};
      end else if (mfifo.size() > 0) begin
         wv = 1'b1;
         w = mfifo.pop_front();
         if (w.rd != 0) pend[w.rd] = 1'b0;
      end
      last_took = mv && rdy;
      if (last_took) mfifo.push_back('{rd: mrd, d: md});
      if (iv && ird != 0) pend[ird] = 1'b1;
      if (wv && w.rd != 0) begin
         expq.push_back('{due: cyc + 1, rd: w.rd, d: w.d});
         lw_v = 1'b1; lw_rd = w.rd; lw_d = w.d;
      end else begin
         lw_v = 1'b0;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n, input logic [4:0] r1);
      for (int i = 0; i < n; i++)
         cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   initial begin
      model_reset();
      #1;
      chk(RFWr == 0 && rd == 0 && DataWr == 0, "reset_outputs",
          {27'd0, RFWr, rd, DataWr}, 64'd0);
      chk(mem_ready == 1'b1, "reset_mem_ready", 64'(mem_ready), 64'd1);
      chk(stall_rs1 == 0 && stall_rs2 == 0, "reset_stall",
          {stall_rs1, stall_rs2}, 64'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK);
      #1;

      // ALU only
      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
      idle(2, 5);

      // ALU versus FIFO head
      cycle(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 7, 32'h0000_0777, 7, 0);
      cycle(1, 3, 32'h0000_0333, 0, 0, 0, 0, 0, 7, 3);
      idle(3, 7);

      // Scoreboard hold-off on a load
      cycle(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
      idle(3, 9);
      cycle(0, 0, 0, 0, 0, 1, 9, 32'h9999_0009, 9, 9);
      idle(3, 9);

      // FIFO fills while ALU owns the port
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 5'(11 + i), 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         cycle(1, 5'(20 + i), 32'(i), 0, 0, 1, 5'(11 + i), 32'(32'hA0 + i), 5'(11 + i), 0);
      cycle(1, 24, 32'h24, 0, 0, 1, 15, 32'hBAD, 0, 0);
      chk(last_took == 1'b0, "full_no_accept", 64'(last_took), 64'd0);
      idle(6, 14);

      // x0 writes from both sources
      cycle(1, 0, 32'h1234, 1, 0, 1, 0, 32'h5678, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2, 0);

      // Reset in the middle of traffic
      cycle(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h11, 0, 0, 1, 9, 32'h99, 9, 10);
      cycle(1, 2, 32'h22, 0, 0, 1, 10, 32'hAA, 9, 10);
      cycle(1, 3, 32'h33, 0, 0, 1, 0, 32'hBB, 9, 10);
      cycle(1, 4, 32'h44, 0, 0, 0, 0, 0, 9, 10);
      #2 RST = 1'b1;
      model_reset();
      #1;
      chk(RFWr == 1'b0, "async_rfwr", 64'(RFWr), 64'd0);
      chk(mem_ready == 1'b1, "async_mem_ready", 64'(mem_ready), 64'd1);
      chk(stall_rs1 == 0 && stall_rs2 == 0, "async_stall",
          {stall_rs1, stall_rs2}, 64'd0);
      alu_valid = 0; mem_valid = 0; iss_valid = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK);
      #1;
      idle(6, 9);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bit          av, iv, mv;
         logic [4:0]  ard, ird, mrd, r1, r2;
         logic [31:0] ad, md;
         av  = ($urandom_range(0, 99) < 45);
         ard = 5'($urandom);
         if (ard != 0 && pend[ard]) av = 1'b0;
         ad  = $urandom;
         iv  = (outst.size() < 6) && ($urandom_range(0, 99) < 35);
         ird = 5'($urandom);
         if (ird != 0 && pend[ird]) iv = 1'b0;
         foreach (outst[k]) if (ird != 0 && outst[k] == ird) iv = 1'b0;
         mv  = (outst.size() > 0) && ($urandom_range(0, 99) < 50);
         mrd = (outst.size() > 0) ? outst[0] : 5'd0;
         md  = $urandom;
         r1  = ($urandom_range(0, 1) == 0 && outst.size() > 0) ? outst[0] : 5'($urandom);
         r2  = lw_v ? lw_rd : 5'($urandom);
         cycle(av, ard, ad, iv, ird, mv, mrd, md, r1, r2);
         if (last_took) void'(outst.pop_front());
         if (iv) outst.push_back(ird);
      end
      while (outst.size() > 0) begin
         cycle(0, 0, 0, 0, 0, 1, outst[0], $urandom, outst[0], 0);
         if (last_took) void'(outst.pop_front());
      end
      idle(8, 0);
      chk(expq.size() == 0, "drain_empty", 64'(expq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
